// File: rtl/cdma_a_wr.sv
// Aligned write CDMA: splits queued (paddr,len) commands into block-aligned AXI4 INCR write bursts,
// forwards AXIS payload onto W combinationally, and pulses wr_done once every B of a command is back.
module cdma_a_wr #(
  parameter int BURST_LEN         = 16,
  parameter int DATA_BITS         = 256,
  parameter int ADDR_BITS         = 34,
  parameter int LEN_BITS          = 32,
  parameter int ID_BITS           = 6,
  parameter int BURST_OUTSTANDING = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_BITS-1:0]   wr_paddr,
  input  logic [LEN_BITS-1:0]    wr_len,
  output logic                   wr_done,
  output logic                   wr_err,
  output logic                   m_axi_ddr_awvalid,
  input  logic                   m_axi_ddr_awready,
  output logic [ADDR_BITS-1:0]   m_axi_ddr_awaddr,
  output logic [ID_BITS-1:0]     m_axi_ddr_awid,
  output logic [7:0]             m_axi_ddr_awlen,
  output logic [2:0]             m_axi_ddr_awsize,
  output logic [1:0]             m_axi_ddr_awburst,
  output logic                   m_axi_ddr_awlock,
  output logic [3:0]             m_axi_ddr_awcache,
  output logic [2:0]             m_axi_ddr_awprot,
  output logic                   m_axi_ddr_wvalid,
  input  logic                   m_axi_ddr_wready,
  output logic [DATA_BITS-1:0]   m_axi_ddr_wdata,
  output logic [DATA_BITS/8-1:0] m_axi_ddr_wstrb,
  output logic                   m_axi_ddr_wlast,
  input  logic                   m_axi_ddr_bvalid,
  output logic                   m_axi_ddr_bready,
  input  logic [ID_BITS-1:0]     m_axi_ddr_bid,
  input  logic [1:0]             m_axi_ddr_bresp,
  input  logic                   s_axis_ddr_tvalid,
  output logic                   s_axis_ddr_tready,
  input  logic [DATA_BITS-1:0]   s_axis_ddr_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_ddr_tkeep,
  input  logic                   s_axis_ddr_tlast
);
  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int BB_LOG     = $clog2(BEAT_BYTES);
  localparam int OUT_W      = $clog2(BURST_OUTSTANDING + 1);
  localparam int QD         = 4;

  typedef enum logic {S_IDLE, S_SPLIT} state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  len;
  } cmd_t;

  state_e               state_q, state_d;
  cmd_t                 cq_q [QD];
  cmd_t                 cq_d [QD];
  logic [1:0]           cq_wp_q, cq_wp_d, cq_rp_q, cq_rp_d;
  logic [2:0]           cq_cnt_q, cq_cnt_d;
  logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic [LEN_BITS-1:0]  nburst_q, nburst_d;
  logic                 awvalid_q, awvalid_d;
  logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
  logic [7:0]           awlen_q, awlen_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [7:0]           bl_q [QD];
  logic [7:0]           bl_d [QD];
  logic [1:0]           bl_wp_q, bl_wp_d, bl_rp_q, bl_rp_d;
  logic [2:0]           bl_cnt_q, bl_cnt_d;
  logic [7:0]           beat_q, beat_d;
  logic [LEN_BITS-1:0]  dn_q [QD];
  logic [LEN_BITS-1:0]  dn_d [QD];
  logic [1:0]           dn_wp_q, dn_wp_d, dn_rp_q, dn_rp_d;
  logic [2:0]           dn_cnt_q, dn_cnt_d;
  logic [LEN_BITS-1:0]  brcv_q, brcv_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 cmd_push, cmd_pop, aw_hs, w_active, w_hs, w_last, b_hs;
  logic                 bl_pop, dn_pop;
  logic [ADDR_BITS-1:0] beat_idx;
  logic [LEN_BITS-1:0]  room, beats, hs_beats;
  logic [1:0]           nxt_rp;
  logic                 unused_ok;

  assign wr_ready = (cq_cnt_q != 3'd4);
  assign cmd_push = wr_valid && wr_ready;
  assign aw_hs    = awvalid_q && m_axi_ddr_awready;
  assign w_active = (bl_cnt_q != 3'd0);
  assign w_hs     = s_axis_ddr_tvalid && m_axi_ddr_wready && w_active;
  assign w_last   = w_active && (beat_q == bl_q[bl_rp_q]);
  // Bursts of a command may complete before its last AW is issued, so B is
  // accepted whenever anything is outstanding rather than waiting for a done entry.
  assign m_axi_ddr_bready = (out_q != '0);
  assign b_hs     = m_axi_ddr_bvalid && m_axi_ddr_bready;

  assign beat_idx = cur_addr_q >> BB_LOG;
  assign room     = LEN_BITS'(BURST_LEN) - LEN_BITS'(beat_idx & ADDR_BITS'(BURST_LEN - 1));
  assign beats    = (rem_q < room) ? rem_q : room;
  assign hs_beats = LEN_BITS'(awlen_q) + LEN_BITS'(1);
  assign nxt_rp   = cq_rp_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    cq_d       = cq_q;
    cq_wp_d    = cq_wp_q;
    cq_rp_d    = cq_rp_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    nburst_d   = nburst_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    bl_d       = bl_q;
    bl_wp_d    = bl_wp_q;
    bl_rp_d    = bl_rp_q;
    beat_d     = beat_q;
    dn_d       = dn_q;
    dn_wp_d    = dn_wp_q;
    dn_rp_d    = dn_rp_q;
    brcv_d     = brcv_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cmd_pop    = 1'b0;
    bl_pop     = 1'b0;
    dn_pop     = 1'b0;

    if (cmd_push) begin
      cq_d[cq_wp_q] = '{addr: wr_paddr, len: wr_len};
      cq_wp_d       = cq_wp_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cq_cnt_q != 3'd0) begin
          cur_addr_d = cq_q[cq_rp_q].addr;
          rem_d      = cq_q[cq_rp_q].len >> BB_LOG;
          nburst_d   = '0;
          state_d    = S_SPLIT;
        end
      end
      default: begin
        if (!awvalid_q) begin
          if (out_q < OUT_W'(BURST_OUTSTANDING) && bl_cnt_q != 3'd4 && dn_cnt_q != 3'd4) begin
            awvalid_d = 1'b1;
            awaddr_d  = cur_addr_q;
            awlen_d   = 8'(beats - LEN_BITS'(1));
          end
        end else if (aw_hs) begin
          awvalid_d        = 1'b0;
          bl_d[bl_wp_q]    = awlen_q;
          bl_wp_d          = bl_wp_q + 2'd1;
          cur_addr_d       = cur_addr_q + (ADDR_BITS'(hs_beats) << BB_LOG);
          rem_d            = rem_q - hs_beats;
          nburst_d         = nburst_q + LEN_BITS'(1);
          if (rem_q == hs_beats) begin
            cmd_pop       = 1'b1;
            cq_rp_d       = nxt_rp;
            dn_d[dn_wp_q] = nburst_q + LEN_BITS'(1);
            dn_wp_d       = dn_wp_q + 2'd1;
            // Chain straight into the next queued command to avoid an idle cycle.
            if (cq_cnt_q > 3'd1) begin
              cur_addr_d = cq_q[nxt_rp].addr;
              rem_d      = cq_q[nxt_rp].len >> BB_LOG;
              nburst_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
    endcase

    if (w_hs) begin
      if (w_last) begin
        beat_d  = '0;
        bl_pop  = 1'b1;
        bl_rp_d = bl_rp_q + 2'd1;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end

    if (b_hs) begin
      if (m_axi_ddr_bresp[1]) err_d = 1'b1;
      if (dn_cnt_q != 3'd0 && (brcv_q + LEN_BITS'(1)) == dn_q[dn_rp_q]) begin
        dn_pop  = 1'b1;
        dn_rp_d = dn_rp_q + 2'd1;
        brcv_d  = '0;
        done_d  = 1'b1;
      end else begin
        brcv_d = brcv_q + LEN_BITS'(1);
      end
    end

    cq_cnt_d = cq_cnt_q + {2'b0, cmd_push} - {2'b0, cmd_pop};
    bl_cnt_d = bl_cnt_q + {2'b0, aw_hs} - {2'b0, bl_pop};
    dn_cnt_d = dn_cnt_q + {2'b0, cmd_pop} - {2'b0, dn_pop};
    out_d    = out_q + OUT_W'(aw_hs) - OUT_W'(b_hs);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < QD; i++) begin
        cq_q[i] <= '0;
        bl_q[i] <= '0;
        dn_q[i] <= '0;
      end
      cq_wp_q    <= '0;
      cq_rp_q    <= '0;
      cq_cnt_q   <= '0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      nburst_q   <= '0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      out_q      <= '0;
      bl_wp_q    <= '0;
      bl_rp_q    <= '0;
      bl_cnt_q   <= '0;
      beat_q     <= '0;
      dn_wp_q    <= '0;
      dn_rp_q    <= '0;
      dn_cnt_q   <= '0;
      brcv_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cq_q       <= cq_d;
      bl_q       <= bl_d;
      dn_q       <= dn_d;
      cq_wp_q    <= cq_wp_d;
      cq_rp_q    <= cq_rp_d;
      cq_cnt_q   <= cq_cnt_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      nburst_q   <= nburst_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      out_q      <= out_d;
      bl_wp_q    <= bl_wp_d;
      bl_rp_q    <= bl_rp_d;
      bl_cnt_q   <= bl_cnt_d;
      beat_q     <= beat_d;
      dn_wp_q    <= dn_wp_d;
      dn_rp_q    <= dn_rp_d;
      dn_cnt_q   <= dn_cnt_d;
      brcv_q     <= brcv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_done           = done_q;
  assign wr_err            = err_q;
  assign m_axi_ddr_awvalid = awvalid_q;
  assign m_axi_ddr_awaddr  = awaddr_q;
  assign m_axi_ddr_awlen   = awlen_q;
  assign m_axi_ddr_awid    = '0;
  assign m_axi_ddr_awsize  = 3'(BB_LOG);
  assign m_axi_ddr_awburst = 2'b01;
  assign m_axi_ddr_awlock  = 1'b0;
  assign m_axi_ddr_awcache = 4'b0011;
  assign m_axi_ddr_awprot  = 3'b000;
  assign m_axi_ddr_wvalid  = s_axis_ddr_tvalid && w_active;
  assign s_axis_ddr_tready = m_axi_ddr_wready && w_active;
  assign m_axi_ddr_wdata   = s_axis_ddr_tdata;
  assign m_axi_ddr_wstrb   = s_axis_ddr_tkeep;
  assign m_axi_ddr_wlast   = w_last;

  assign unused_ok = ^{m_axi_ddr_bid, s_axis_ddr_tlast, m_axi_ddr_bresp[0]};
endmodule

// File: tb/tb_cdma_a_wr.sv
// Bench for cdma_a_wr: randomized AXI slave / AXIS source, scoreboard of expected AW, W and done
// events derived from a burst-splitting reference model.
module tb_cdma_a_wr;
  localparam int BL = 16;
  localparam int BB = 32;
  localparam int LIMIT = 2;

  typedef struct { longint addr; int len; } aw_t;
  typedef struct { logic [255:0] data; logic [31:0] strb; logic last; } w_t;

  logic aclk = 0, aresetn = 0;
  logic wr_valid = 0, wr_ready, wr_done, wr_err;
  logic [31:0] wr_paddr = 0, wr_len = 0;
  logic awvalid, awready = 0, awlock, wvalid, wready = 0, wlast;
  logic [31:0] awaddr; logic [3:0] awid, bid = 0; logic [7:0] awlen;
  logic [2:0] awsize, awprot; logic [1:0] awburst, bresp = 0; logic [3:0] awcache;
  logic [255:0] wdata, tdata = 0; logic [31:0] wstrb, tkeep = 0;
  logic bvalid = 0, bready, tvalid = 0, tready, tlast = 0;

  aw_t exp_aw[$]; w_t exp_w[$]; w_t src_q[$]; int b_left[$];
  int n_total = 0, n_bad = 0, cyc = 0, last_b_cyc = -10;
  int aw_acc = 0, wl_cnt = 0, b_issued = 0, b_done = 0, w_seen = 0, done_cnt = 0;
  int wready_pct = 80;
  bit aw_stall = 0, b_hold = 0, err_inject = 0, err_exp = 0;

  cdma_a_wr #(.BURST_LEN(BL), .DATA_BITS(256), .ADDR_BITS(32), .LEN_BITS(32), .ID_BITS(4),
              .BURST_OUTSTANDING(LIMIT)) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_paddr(wr_paddr), .wr_len(wr_len), .wr_done(wr_done), .wr_err(wr_err),
    .m_axi_ddr_awvalid(awvalid), .m_axi_ddr_awready(awready), .m_axi_ddr_awaddr(awaddr),
    .m_axi_ddr_awid(awid), .m_axi_ddr_awlen(awlen), .m_axi_ddr_awsize(awsize),
    .m_axi_ddr_awburst(awburst), .m_axi_ddr_awlock(awlock), .m_axi_ddr_awcache(awcache),
    .m_axi_ddr_awprot(awprot), .m_axi_ddr_wvalid(wvalid), .m_axi_ddr_wready(wready),
    .m_axi_ddr_wdata(wdata), .m_axi_ddr_wstrb(wstrb), .m_axi_ddr_wlast(wlast),
    .m_axi_ddr_bvalid(bvalid), .m_axi_ddr_bready(bready), .m_axi_ddr_bid(bid),
    .m_axi_ddr_bresp(bresp), .s_axis_ddr_tvalid(tvalid), .s_axis_ddr_tready(tready),
    .s_axis_ddr_tdata(tdata), .s_axis_ddr_tkeep(tkeep), .s_axis_ddr_tlast(tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input bit ok, input string nm, input string msg);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  // Reference model: chop the byte range at every BL*BB-byte block boundary.
  task automatic model_cmd(input longint addr, input int len);
    longint a; int rem, blk, to_bound, bytes, beats, nb;
    w_t w;
    a = addr; rem = len; blk = BL * BB; nb = 0;
    while (rem > 0) begin
      to_bound = blk - int'(a % blk);
      bytes = (rem < to_bound) ? rem : to_bound;
      beats = bytes / BB;
      exp_aw.push_back('{a, beats - 1});
      for (int i = 0; i < beats; i++) begin
        w.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        w.strb = $urandom;
        w.last = (i == beats - 1);
        src_q.push_back(w);
        exp_w.push_back(w);
      end
      a += bytes; rem -= bytes; nb++;
    end
    b_left.push_back(nb);
  endtask

  task automatic send_cmd(input longint addr, input int len);
    bit hs; int n;
    model_cmd(addr, len);
    wr_paddr = 32'(addr); wr_len = 32'(len); wr_valid = 1; hs = 0; n = 0;
    while (!hs) begin
      @(negedge aclk); hs = wr_ready;
      @(posedge aclk); #1;
      n++;
      if (!hs && n > 3000) begin
        chk(0, "cmd_accept", $sformatf("wr_ready stayed %0b for %0d cycles, required 1", wr_ready, n));
        break;
      end
    end
    wr_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((b_left.size() != 0 || exp_w.size() != 0 || exp_aw.size() != 0) && n < budget) begin
      @(posedge aclk); #1; n++;
    end
    chk(n < budget, "idle", $sformatf("pending aw=%0d w=%0d cmds=%0d, required all 0",
        exp_aw.size(), exp_w.size(), b_left.size()));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); src_q.delete(); b_left.delete();
    aw_acc = 0; wl_cnt = 0; b_issued = 0; b_done = 0; w_seen = 0;
    err_exp = 0; b_hold = 0; err_inject = 0; aw_stall = 0;
  endtask

  // Monitor / scoreboard
  always @(negedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (wr_done) begin
        if (b_left.size() == 0) chk(0, "done_extra", "wr_done with no command pending, required 0");
        else begin
          chk(b_left[0] == 0 && last_b_cyc == cyc - 1, "done_timing",
              $sformatf("bursts left=%0d last B cycle=%0d now=%0d, required 0 and now-1", b_left[0], last_b_cyc, cyc));
          chk(wr_err == err_exp, "done_err", $sformatf("wr_err=%0b, required %0b", wr_err, err_exp));
          void'(b_left.pop_front());
        end
        done_cnt++;
      end
      if (bvalid && bready) begin
        b_done++;
        last_b_cyc = cyc;
        if (bresp[1]) err_exp = 1;
        if (b_left.size() == 0) chk(0, "b_extra", "B with no command pending");
        else b_left[0] = b_left[0] - 1;
      end
      if (wvalid && wready) begin
        w_seen++;
        chk(wl_cnt < aw_acc, "w_before_aw", $sformatf("W beat with bursts done=%0d aw=%0d, required done<aw", wl_cnt, aw_acc));
        if (exp_w.size() == 0) chk(0, "w_extra", "W beat with none expected");
        else begin
          chk(wdata == exp_w[0].data && wstrb == exp_w[0].strb && wlast == exp_w[0].last, "w_beat",
              $sformatf("strb=%h last=%0b data=%h, required strb=%h last=%0b data=%h",
                        wstrb, wlast, wdata, exp_w[0].strb, exp_w[0].last, exp_w[0].data));
          void'(exp_w.pop_front());
        end
        if (wlast) wl_cnt++;
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) chk(0, "aw_extra", $sformatf("AW addr=%h with none expected", awaddr));
        else begin
          chk(longint'(awaddr) == exp_aw[0].addr && int'(awlen) == exp_aw[0].len && awsize == 3'd5 &&
              awburst == 2'b01 && awcache == 4'b0011 && awid == 0 && !awlock && awprot == 0, "aw",
              $sformatf("addr=%h len=%0d size=%0d burst=%0d cache=%h, required addr=%h len=%0d size=5 burst=1 cache=3",
                        awaddr, awlen, awsize, awburst, awcache, exp_aw[0].addr, exp_aw[0].len));
          void'(exp_aw.pop_front());
        end
        aw_acc++;
        chk(aw_acc - b_done <= LIMIT, "outstanding",
            $sformatf("outstanding=%0d, required <= %0d", aw_acc - b_done, LIMIT));
      end
    end
  end

  // AW slave
  initial forever begin
    @(posedge aclk); #1;
    awready = aresetn && !aw_stall && ($urandom_range(0, 3) != 0);
  end

  // W slave
  initial forever begin
    @(posedge aclk); #1;
    wready = aresetn && ($urandom_range(0, 99) < wready_pct);
  end

  // AXIS source
  initial forever begin
    bit hs;
    @(negedge aclk); hs = aresetn && tvalid && tready;
    @(posedge aclk); #1;
    if (hs && src_q.size() > 0) void'(src_q.pop_front());
    if (!aresetn) tvalid = 0;
    else if (tvalid && !hs) tvalid = 1;
    else if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      tvalid = 1; tdata = src_q[0].data; tkeep = src_q[0].strb; tlast = $urandom;
    end else tvalid = 0;
  end

  // B responder: one B per burst whose AW and last W beat have both been seen
  initial forever begin
    bit hs;
    int ready_n;
    @(negedge aclk); hs = aresetn && bvalid && bready;
    @(posedge aclk); #1;
    ready_n = (aw_acc < wl_cnt) ? aw_acc : wl_cnt;
    if (!aresetn) bvalid = 0;
    else if (bvalid && !hs) bvalid = 1;
    else begin
      bvalid = 0;
      if (!b_hold && ready_n > b_issued && $urandom_range(0, 1) == 1) begin
        bvalid = 1; bid = 4'($urandom);
        bresp = err_inject ? 2'b10 : 2'b00;
        err_inject = 0;
        b_issued++;
      end
    end
  end

  initial begin
    int base, n;
    cycles(3);
    chk(!awvalid && !wvalid && !bready && !wr_done && !wr_err && !tready && wr_ready, "reset_state",
        $sformatf("awvalid=%0b wvalid=%0b bready=%0b done=%0b err=%0b tready=%0b wr_ready=%0b, required 0 0 0 0 0 0 1",
                  awvalid, wvalid, bready, wr_done, wr_err, tready, wr_ready));
    aresetn = 1;
    cycles(2);

    base = aw_acc;
    send_cmd(64'h0, 1024); wait_idle(2000);
    chk(aw_acc - base == 2, "t1_aw_count", $sformatf("%0d AW, required 2", aw_acc - base));

    base = aw_acc;
    send_cmd(64'h1E0, 128); wait_idle(2000);
    chk(aw_acc - base == 2, "t2_aw_count", $sformatf("%0d AW, required 2", aw_acc - base));

    wready_pct = 50; aw_stall = 1; base = done_cnt;
    for (int i = 0; i < 4; i++) send_cmd(64'h1000 + i * 64, 32);
    @(negedge aclk);
    chk(!wr_ready, "t3_queue_full", $sformatf("wr_ready=%0b, required 0", wr_ready));
    chk(awvalid, "t3_aw_held", $sformatf("awvalid=%0b, required 1", awvalid));
    @(posedge aclk); #1; aw_stall = 0;
    wait_idle(2000);
    chk(done_cnt - base == 4, "t3_done_count", $sformatf("%0d done, required 4", done_cnt - base));

    wready_pct = 80; b_hold = 1; base = aw_acc;
    send_cmd(64'h4000, 2048);
    cycles(150);
    chk(aw_acc - base == 2 && !awvalid, "t4_stall",
        $sformatf("%0d AW issued, awvalid=%0b, required 2 and 0", aw_acc - base, awvalid));
    b_hold = 0; wait_idle(3000);
    chk(aw_acc - base == 4, "t4_resume", $sformatf("%0d AW, required 4", aw_acc - base));

    chk(!wr_err, "t5_err_before", $sformatf("wr_err=%0b, required 0", wr_err));
    err_inject = 1; base = done_cnt;
    send_cmd(64'h8000, 512); wait_idle(2000);
    chk(wr_err && done_cnt - base == 1, "t5_err_set",
        $sformatf("wr_err=%0b done=%0d, required 1 and 1", wr_err, done_cnt - base));
    send_cmd(64'h8200, 256); wait_idle(2000);
    chk(wr_err, "t5_err_sticky", $sformatf("wr_err=%0b, required 1", wr_err));

    send_cmd(64'hA000, 1024);
    n = 0;
    while (w_seen < 5 && n < 1000) begin cycles(1); n++; end
    chk(n < 1000, "t6_wait_beats", $sformatf("%0d W beats seen, required >= 5", w_seen));
    @(posedge aclk); #2;
    aresetn = 0; flush();
    @(negedge aclk);
    chk(!awvalid && !wvalid && !bready && !wr_done && !wr_err, "t6_reset_mid",
        $sformatf("awvalid=%0b wvalid=%0b bready=%0b done=%0b err=%0b, required all 0",
                  awvalid, wvalid, bready, wr_done, wr_err));
    cycles(3); aresetn = 1;
    @(negedge aclk);
    chk(wr_ready, "t6_ready_after", $sformatf("wr_ready=%0b, required 1", wr_ready));
    @(posedge aclk); #1;
    base = done_cnt;
    send_cmd(64'h3000, 640); wait_idle(2000);
    chk(done_cnt - base == 1, "t6_fresh_cmd", $sformatf("%0d done, required 1", done_cnt - base));

    base = done_cnt;
    for (int i = 0; i < 20; i++) begin
      wready_pct = $urandom_range(30, 100);
      send_cmd(longint'($urandom_range(0, 4095)) * BB, $urandom_range(1, 40) * BB);
    end
    wait_idle(20000);
    chk(done_cnt - base == 20, "rand_done_count", $sformatf("%0d done, required 20", done_cnt - base));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
